fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the synchronous FIFO between NUM_REQ producers.
- Grants one producer at a time in bursts of up to MAX_BURST beats.
- Stalls on FIFO full and hands off to the next requester without a bubble.
- Sits directly in front of the FIFO write side (wr_en/wr_data/full) and keeps a saturating count of accepted writes.

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats, stalls on full, hands off without a bubble.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int OW       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    output logic [15:0]               wr_count
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic [15:0]   wr_count_q, wr_count_d;

    logic          req_own;
    logic          xfer;
    logic [3:0]    beat_inc;
    logic          last_beat;

    // First requester after base, wrapping; base itself is searched last.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [OW-1:0] base);
        logic [OW-1:0] sel;
        logic [OW-1:0] cand;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(base) + k) % NUM_REQ;
            cand = OW'(idx);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign req_own   = req[owner_q];
    assign busy      = (state_q == BURST);
    assign xfer      = busy && !fifo_full && req_own;
    assign beat_inc  = beat_cnt_q + 4'd1;
    assign last_beat = xfer && (beat_inc == 4'(MAX_BURST));

    assign fifo_wr_en = xfer;
    assign owner      = owner_q;
    assign wr_count   = wr_count_q;

    always_comb begin
        gnt = '0;
        if (busy && !fifo_full) begin
            gnt[owner_q] = 1'b1;
        end
    end

    always_comb begin
        fifo_wr_data = '0;
        if (busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == OW'(i)) begin
                    fifo_wr_data = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        wr_count_d   = wr_count_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = rr_pick(req, last_owner_q);
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_inc;
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                end
                // The ending owner becomes last_owner, so it is searched last.
                if (!req_own || last_beat) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    if (|req) begin
                        owner_d = rr_pick(req, owner_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a
// randomized run against a per-cycle behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [1:0]    owner;
    logic          busy;
    logic [15:0]   wr_count;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .owner(owner), .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Producer word queues; a producer requests while its queue is non-empty.
    logic [7:0] pq[N][$];
    bit         use_q;

    // Reference model: who holds the port, who held it last, beats still allowed.
    bit m_active;
    int m_owner, m_last, m_left, m_cnt;

    int         cyc, first_wr, last_wr;
    logic [7:0] cap_d[$];
    int         cap_o[$];
    logic [7:0] ed[$];
    int         eo[$];

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_owner = 0; m_last = N - 1; m_left = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit x;
        int p;
        if (rst) begin
            model_reset();
        end else if (!m_active) begin
            p = pick(req, m_last);
            if (p >= 0) begin
                m_owner = p; m_left = MB; m_active = 1;
            end
        end else begin
            x = !fifo_full && req[m_owner];
            if (x) begin
                m_left--;
                if (m_cnt < 65535) m_cnt++;
                if (use_q) void'(pq[m_owner].pop_front());
            end
            if (!req[m_owner] || m_left == 0) begin
                m_last = m_owner;
                p = pick(req, m_last);
                if (p >= 0) begin
                    m_owner = p; m_left = MB;
                end else begin
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] eg;
        logic         ex;
        logic [7:0]   edat;
        if (use_q) begin
            for (int i = 0; i < N; i++) begin
                req[i] = (pq[i].size() > 0);
                req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
            end
        end
        @(negedge clk);
        eg   = (m_active && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
        ex   = m_active && !fifo_full && req[m_owner];
        edat = m_active ? req_data[m_owner*DW +: DW] : 8'h00;
        chk($sformatf("c%0d_gnt", cyc), 32'(gnt), 32'(eg));
        chk($sformatf("c%0d_wr_en", cyc), 32'(fifo_wr_en), 32'(ex));
        chk($sformatf("c%0d_wr_data", cyc), 32'(fifo_wr_data), 32'(edat));
        chk($sformatf("c%0d_busy", cyc), 32'(busy), 32'(m_active));
        chk($sformatf("c%0d_wr_count", cyc), 32'(wr_count), 32'(m_cnt));
        if (m_active) chk($sformatf("c%0d_owner", cyc), 32'(owner), 32'(m_owner));
        if (fifo_wr_en) begin
            cap_d.push_back(fifo_wr_data);
            cap_o.push_back(int'(owner));
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic clear_log();
        cap_d.delete(); cap_o.delete();
        first_wr = -1; last_wr = -1; cyc = 0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; use_q = 1;
        for (int i = 0; i < N; i++) pq[i].delete();
        model_reset();
        #1;
        chk({nm, "_rst_gnt"}, 32'(gnt), 32'h0);
        chk({nm, "_rst_wr_en"}, 32'(fifo_wr_en), 32'h0);
        chk({nm, "_rst_busy"}, 32'(busy), 32'h0);
        chk({nm, "_rst_count"}, 32'(wr_count), 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_nwrites"}, 32'(cap_d.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size() && i < cap_d.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), 32'(cap_d[i]), 32'(ed[i]));
            chk($sformatf("%s_own%0d", nm, i), 32'(cap_o[i]), 32'(eo[i]));
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic [3:0]  gnt;
        logic        wr;
        logic [7:0]  data;
        logic        busy;
        logic [1:0]  own;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[11];
    int   cnt_d;

    initial begin
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0};
        tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2, 16'd0};
        tbl[3]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'hA2, 1'b1, 2'd2, 16'd1};
        tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2, 16'd1};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0100, 1'b0, 8'hA2, 1'b1, 2'd2, 16'd2};
        tbl[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd2};
        tbl[7]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 8'hA3, 1'b1, 2'd3, 16'd2};
        tbl[8]  = '{4'b0010, 1'b0, 4'b1000, 1'b0, 8'hA3, 1'b1, 2'd3, 16'd3};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1, 16'd3};
        tbl[10] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1, 16'd4};

        // Vector table with fixed producer words 0xA0+i.
        do_reset("tbl");
        use_q = 0;
        req_data = 32'hA3A2A1A0;
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req;
            fifo_full = tbl[i].full;
            #2;
            chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("t%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].wr));
            chk($sformatf("t%0d_data", i), 32'(fifo_wr_data), 32'(tbl[i].data));
            chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("t%0d_cnt", i), 32'(wr_count), 32'(tbl[i].cnt));
            if (tbl[i].busy) chk($sformatf("t%0d_own", i), 32'(owner), 32'(tbl[i].own));
            cycle();
        end

        // Sole requester, 6 words: one bubble, 4 beats, immediate re-grant, 2 beats.
        do_reset("solo");
        for (int k = 0; k < 6; k++) pq[0].push_back(8'(8'h10 + k));
        repeat (10) cycle();
        ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        eo = '{0, 0, 0, 0, 0, 0};
        chk_log("solo");
        chk("solo_first_wr", 32'(first_wr), 32'd1);
        chk("solo_last_wr", 32'(last_wr), 32'd6);
        chk("solo_count", 32'(wr_count), 32'd6);
        chk("solo_idle", 32'(busy), 32'd0);

        // All four requesting: bursts of 4 to 0,1,2,3,0 back to back.
        do_reset("all");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 10; k++) pq[i].push_back(8'(i * 16 + k));
        repeat (21) cycle();
        ed.delete(); eo.delete();
        begin
            int per[N];
            for (int i = 0; i < N; i++) per[i] = 0;
            for (int w = 0; w < 20; w++) begin
                int o;
                o = (w / MB) % N;
                ed.push_back(8'(o * 16 + per[o]));
                eo.push_back(o);
                per[o]++;
            end
        end
        chk_log("all");
        chk("all_first_wr", 32'(first_wr), 32'd1);
        chk("all_last_wr", 32'(last_wr), 32'd20);
        chk("all_count", 32'(wr_count), 32'd20);

        // Producer 2 stalled by full for 3 cycles after beat 2.
        do_reset("full");
        for (int k = 0; k < 4; k++) pq[2].push_back(8'(8'h20 + k));
        for (int c = 0; c < 10; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            cycle();
        end
        fifo_full = 1'b0;
        ed = '{8'h20, 8'h21, 8'h22, 8'h23};
        eo = '{2, 2, 2, 2};
        chk_log("full");
        chk("full_first_wr", 32'(first_wr), 32'd1);
        chk("full_last_wr", 32'(last_wr), 32'd7);
        chk("full_count", 32'(wr_count), 32'd4);

        // Producer 1 drops after 2 beats; 3 takes over; then 0 is searched before 1.
        do_reset("drop");
        pq[1].push_back(8'h31); pq[1].push_back(8'h32);
        pq[3].push_back(8'h61); pq[3].push_back(8'h62);
        for (int c = 0; c < 12; c++) begin
            if (c == 4) begin
                pq[0].push_back(8'h05);
                pq[1].push_back(8'h33);
            end
            cycle();
        end
        ed = '{8'h31, 8'h32, 8'h61, 8'h62, 8'h05, 8'h33};
        eo = '{1, 1, 3, 3, 0, 1};
        chk_log("drop");

        // Asynchronous reset in the middle of producer 2's burst.
        do_reset("arst");
        for (int k = 0; k < 4; k++) pq[2].push_back(8'(8'h40 + k));
        repeat (3) cycle();
        chk("arst_pre_busy", 32'(busy), 32'd1);
        chk("arst_pre_owner", 32'(owner), 32'd2);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_count", 32'(wr_count), 32'h0);
        for (int i = 0; i < N; i++) pq[i].delete();
        pq[1].push_back(8'h51);
        pq[2].push_back(8'h52);
        cycle();
        rst = 1'b0;
        clear_log();
        repeat (5) cycle();
        ed = '{8'h51, 8'h52};
        eo = '{1, 2};
        chk_log("arst");

        // Randomized traffic and full against the model.
        do_reset("rand");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && pq[i].size() < 5) pq[i].push_back(8'($urandom));
            fifo_full = ($urandom_range(0, 4) == 0);
            cycle();
        end
        fifo_full = 1'b0;

        // Saturation: 65534 transfers then 3 more.
        do_reset("sat");
        use_q = 0;
        req = 4'b0001;
        req_data = 32'h00000077;
        cnt_d = 0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", 32'(wr_count), 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk("sat_ffff_1", 32'(wr_count), 32'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat_ffff_3", 32'(wr_count), 32'hFFFF);
        chk("sat_wr_en", 32'(fifo_wr_en), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
